// File: rtl/weights_rom_sequencer.sv
// weights_rom_sequencer
//   Walks the weight ROM address space 0..NB_WEIGHTS-1 once per input image
//   for a commanded number of passes. The first and last address of each
//   pass are tagged with sow/eow. Addresses are offered on an rts/rtr
//   valid-ready handshake, one per cycle when the ROM stage is ready.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start_i       one-cycle run command (accepted only in IDLE)
//   nb_pass_i     number of full sweeps, sampled with start_i
//   abort_i       stop the run (honoured only while running)
//   rtr_i         ROM stage ready to receive
//   rts_o         address/framing valid
//   address_o     weight row address
//   sow_o, eow_o  first / last address of a pass
//   busy_o        high while running or finishing
//   done_o        one-cycle pulse at the end of a completed run
//   pass_idx_o    0-based index of the pass being issued
module weights_rom_sequencer #(
    parameter int NB_WEIGHTS = 784,
    parameter int PASS_WIDTH = 16,
    localparam int AW = (NB_WEIGHTS > 1) ? $clog2(NB_WEIGHTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [PASS_WIDTH-1:0] nb_pass_i,
    input  logic                  abort_i,
    input  logic                  rtr_i,
    output logic                  rts_o,
    output logic [AW-1:0]         address_o,
    output logic                  sow_o,
    output logic                  eow_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [PASS_WIDTH-1:0] pass_idx_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NB_WEIGHTS - 1);

    state_e                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [PASS_WIDTH-1:0] pass_q, pass_d;
    logic [PASS_WIDTH-1:0] total_q, total_d;

    logic in_run;
    logic xfer;
    logic last_addr;
    logic last_pass;

    assign in_run    = (state_q == RUN);
    assign xfer      = in_run && rtr_i;
    assign last_addr = (addr_q == LAST_ADDR);
    // total_q is never 0 in RUN, so total_q-1 cannot underflow there.
    assign last_pass = (pass_q == total_q - PASS_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pass_q  <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        total_d = total_q;
        unique case (state_q)
            IDLE: begin
                // abort_i has no effect here, so start always wins.
                if (start_i) begin
                    total_d = nb_pass_i;
                    addr_d  = '0;
                    pass_d  = '0;
                    state_d = (nb_pass_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    // A transfer in this cycle was consumed by the ROM; just drop out.
                    addr_d  = '0;
                    pass_d  = '0;
                    state_d = IDLE;
                end else if (xfer) begin
                    if (!last_addr) begin
                        addr_d = addr_q + AW'(1);
                    end else if (!last_pass) begin
                        // Wrap straight into the next pass, no bubble.
                        addr_d = '0;
                        pass_d = pass_q + PASS_WIDTH'(1);
                    end else begin
                        addr_d  = '0;
                        pass_d  = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registers only; rtr_i never reaches rts_o.
    assign rts_o      = in_run;
    assign address_o  = in_run ? addr_q : '0;
    assign sow_o      = in_run && (addr_q == '0);
    assign eow_o      = in_run && last_addr;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign pass_idx_o = in_run ? pass_q : '0;

endmodule

// File: tb/tb_weights_rom_sequencer.sv
module tb_weights_rom_sequencer;

    localparam int NBW = 784;
    localparam int PW  = 16;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [PW-1:0] nb_pass_i = '0;
    logic          abort_i = 1'b0;
    logic          rtr_i = 1'b1;
    logic          rts_o;
    logic [AW-1:0] address_o;
    logic          sow_o;
    logic          eow_o;
    logic          busy_o;
    logic          done_o;
    logic [PW-1:0] pass_idx_o;

    weights_rom_sequencer #(.NB_WEIGHTS(NBW), .PASS_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .nb_pass_i(nb_pass_i),
        .abort_i(abort_i), .rtr_i(rtr_i), .rts_o(rts_o), .address_o(address_o),
        .sow_o(sow_o), .eow_o(eow_o), .busy_o(busy_o), .done_o(done_o),
        .pass_idx_o(pass_idx_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          sow;
        logic          eow;
        logic [PW-1:0] pass;
    } xfer_t;

    xfer_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected transfer per observed handshake.
    initial begin
        xfer_t got, exp_x, held;
        bit    stall;
        stall = 0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 0;
            end else begin
                got = '{addr: address_o, sow: sow_o, eow: eow_o, pass: pass_idx_o};
                if (stall) begin
                    check("stall_rts_held", 64'(rts_o), 64'(1));
                    check("stall_outputs_frozen", 64'(got), 64'(held));
                end
                if (done_o) done_cnt++;
                if (rts_o && rtr_i) begin
                    if (sb.size() == 0) begin
                        check("unexpected_transfer", 64'(got), 64'h0BAD);
                    end else begin
                        exp_x = sb.pop_front();
                        check("transfer", 64'(got), 64'(exp_x));
                    end
                end
                stall = rts_o && !rtr_i;
                held  = got;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pass(input int p, input int upto);
        for (int a = 0; a <= upto; a++)
            sb.push_back('{addr: AW'(a), sow: (a == 0), eow: (a == NBW-1), pass: PW'(p)});
    endtask

    task automatic do_start(input int n);
        start_i   = 1'b1;
        nb_pass_i = PW'(n);
        tick();
        start_i   = 1'b0;
        nb_pass_i = '0;
    endtask

    // Runs until done_o, then checks completion framing and busy fall.
    task automatic run_to_done(input string name, input int exp_ticks, input bit rnd, input int dn0);
        int n = 0;
        while (!done_o && n < 20000) begin
            if (rnd) rtr_i = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        rtr_i = 1'b1;
        check({name, "_done_seen"}, 64'(done_o), 64'(1));
        if (exp_ticks >= 0) check({name, "_cycles"}, 64'(n), 64'(exp_ticks));
        check({name, "_sb_empty"}, 64'(sb.size()), 64'(0));
        check({name, "_rts_low_in_done"}, 64'(rts_o), 64'(0));
        check({name, "_busy_in_done"}, 64'(busy_o), 64'(1));
        tick();
        check({name, "_busy_fall"}, 64'(busy_o), 64'(0));
        check({name, "_done_pulse_1cyc"}, 64'(done_o), 64'(0));
        check({name, "_done_count"}, 64'(done_cnt), 64'(dn0 + 1));
    endtask

    initial begin
        int dn0;
        int n;

        // Reset state
        #12;
        check("reset_outputs", 64'({rts_o, address_o, sow_o, eow_o, busy_o, done_o, pass_idx_o}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", 64'({rts_o, busy_o, done_o}), 64'(0));

        // 1. Single pass nominal
        dn0 = done_cnt;
        push_pass(0, NBW-1);
        do_start(1);
        check("t1_rts_rise", 64'(rts_o), 64'(1));
        check("t1_first_sow", 64'({sow_o, address_o}), 64'({1'b1, AW'(0)}));
        run_to_done("t1", NBW, 1'b0, dn0);

        // 2. Backpressure
        dn0 = done_cnt;
        push_pass(0, NBW-1);
        do_start(1);
        run_to_done("t2", -1, 1'b1, dn0);

        // 3. Multi-pass, back to back
        dn0 = done_cnt;
        for (int p = 0; p < 3; p++) push_pass(p, NBW-1);
        do_start(3);
        run_to_done("t3", 3*NBW, 1'b0, dn0);

        // 4a. Zero passes: done at start+1, no transfer
        dn0 = done_cnt;
        do_start(0);
        check("t4_zero_done", 64'({done_o, rts_o, busy_o}), 64'({1'b1, 1'b0, 1'b1}));
        tick();
        check("t4_zero_idle", 64'({done_o, busy_o}), 64'(0));
        check("t4_zero_done_count", 64'(done_cnt), 64'(dn0 + 1));

        // 4b. abort in IDLE ignored
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t4_abort_idle", 64'({busy_o, rts_o}), 64'(0));

        // 4c. start during RUN ignored
        dn0 = done_cnt;
        push_pass(0, NBW-1);
        do_start(1);
        repeat (10) tick();
        do_start(5);
        run_to_done("t4c", NBW-11, 1'b0, dn0);

        // 5. Abort on the address-100 transfer
        dn0 = done_cnt;
        push_pass(0, 100);
        do_start(2);
        n = 0;
        while (address_o != AW'(100) && n < 2000) begin
            tick();
            n++;
        end
        check("t5_reached_100", 64'(address_o), 64'(100));
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t5_after_abort", 64'({rts_o, busy_o, sow_o, eow_o, done_o, pass_idx_o}), 64'(0));
        check("t5_sb_empty", 64'(sb.size()), 64'(0));
        repeat (3) tick();
        check("t5_no_done", 64'(done_cnt), 64'(dn0));
        dn0 = done_cnt;
        push_pass(0, NBW-1);
        do_start(1);
        check("t5_restart_sow", 64'({sow_o, address_o, rts_o}), 64'({1'b1, AW'(0), 1'b1}));
        run_to_done("t5r", NBW, 1'b0, dn0);

        // 6. Async reset at address 400 of pass 1
        push_pass(0, NBW-1);
        push_pass(1, 399);
        do_start(2);
        n = 0;
        while (!(pass_idx_o == PW'(1) && address_o == AW'(400)) && n < 3000) begin
            tick();
            n++;
        end
        check("t6_reached_p1_a400", 64'({pass_idx_o, address_o}), 64'({PW'(1), AW'(400)}));
        rst_n = 1'b0;
        #1;
        check("t6_async_reset_outputs", 64'({rts_o, address_o, sow_o, eow_o, busy_o, done_o, pass_idx_o}), 64'(0));
        check("t6_sb_empty", 64'(sb.size()), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("t6_idle_until_start", 64'({rts_o, busy_o, done_o}), 64'(0));
        dn0 = done_cnt;
        push_pass(0, NBW-1);
        do_start(1);
        run_to_done("t6r", NBW, 1'b0, dn0);

        check("final_sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
